channel_demux: RTL and testbench

CHANNEL_DEMUX -- requirements
Module: channel_demux

---
 rtl/channel_demux_pkg.sv | 13 +
 rtl/demux_slot.sv | 54 +++++
 rtl/channel_demux.sv | 83 ++++++++
 tb/tb_channel_demux.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/channel_demux_pkg.sv
// Shared constants and the slot state type for the four-channel demultiplexer.
package channel_demux_pkg;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: loads a word, holds it until drained, and accepts a
// replacement in the same cycle as a drain.
module demux_slot
    import channel_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic [WIDTH-1:0] data_out
);

    slot_state_e      state_r;
    logic [WIDTH-1:0] data_r;

    // Slot state and payload register; a load wins over a drain so there is no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= EMPTY;
            data_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                EMPTY: begin
                    if (load) begin
                        state_r <= FULL;
                        data_r  <= data_in;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                FULL: begin
                    if (load) begin
                        data_r <= data_in;
                    end else if (drain) begin
                        state_r <= EMPTY;
                    end else begin
                        state_r <= FULL;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
        end
    end

    assign full     = (state_r == FULL);
    assign data_out = data_r;

endmodule

// File: rtl/channel_demux.sv
// Routes an input stream to four independent one-entry output slots by address.
// Optional per-channel delivery counters are enabled by CHANNEL_DEMUX_COUNT_EN.
module channel_demux
    import channel_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [WIDTH-1:0]        in_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH*CNT_W-1:0] xfer_cnt
);

    logic [NUM_CH-1:0] full_s;
    logic [NUM_CH-1:0] load_s;
    logic [NUM_CH-1:0] drain_s;

    // A slot can take a word when empty or when its sink drains it this same edge.
    always_comb begin
        in_ready = (~full_s[in_addr]) | out_ready[in_addr];
    end

    // Address decode of an accepted input word onto exactly one slot.
    always_comb begin
        load_s = {NUM_CH{1'b0}};
        if (in_valid && in_ready) begin
            load_s[in_addr] = 1'b1;
        end else begin
            load_s = {NUM_CH{1'b0}};
        end
    end

    assign drain_s   = full_s & out_ready;
    assign out_valid = full_s;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .reset_n  (reset_n),
            .load     (load_s[k]),
            .drain    (drain_s[k]),
            .data_in  (in_data),
            .full     (full_s[k]),
            .data_out (out_data[k*WIDTH +: WIDTH])
        );
    end

`ifdef CHANNEL_DEMUX_COUNT_EN
    logic [CNT_W-1:0] cnt_r [NUM_CH];

    // Delivered-word counters, wrapping naturally at the counter width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_r[k] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (drain_s[k]) begin
                    cnt_r[k] <= cnt_r[k] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_r[k] <= cnt_r[k];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
        assign xfer_cnt[k*CNT_W +: CNT_W] = cnt_r[k];
    end
`else
    assign xfer_cnt = {(NUM_CH*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_channel_demux.sv
// Self-checking bench for channel_demux: vector table, directed sequences and a
// random soak against a per-channel queue scoreboard.
module tb_channel_demux;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_addr;
    logic [7:0]  in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [31:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    channel_demux #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard model
    logic [7:0] sb_q [4][$];
    logic [3:0] model_full = 4'b0000;
    logic [7:0] cnt_model [4];
    int         delivered [4];

    function automatic logic [31:0] exp_cnt();
`ifdef CHANNEL_DEMUX_COUNT_EN
        return {cnt_model[3], cnt_model[2], cnt_model[1], cnt_model[0]};
`else
        return 32'd0;
`endif
    endfunction

    // Monitor on the falling edge: compare, then advance the model for the coming rising edge.
    always @(negedge clk) begin
        logic model_ready;
        logic [7:0] popped;
        if (!reset_n) begin
            model_full = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                sb_q[k].delete();
                cnt_model[k] = 8'd0;
            end
        end else begin
            model_ready = ~model_full[in_addr] | out_ready[in_addr];
            chk("out_valid", {28'd0, out_valid}, {28'd0, model_full});
            chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready});
            chk("xfer_cnt", xfer_cnt, exp_cnt());
            for (int k = 0; k < 4; k++) begin
                if (model_full[k] && sb_q[k].size() > 0)
                    chk("out_data", {24'd0, out_data[k*8 +: 8]}, {24'd0, sb_q[k][0]});
            end
            for (int k = 0; k < 4; k++) begin
                if (model_full[k] && out_ready[k]) begin
                    if (sb_q[k].size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        popped = sb_q[k].pop_front();
                        chk("drain_data", {24'd0, out_data[k*8 +: 8]}, {24'd0, popped});
                    end
                    model_full[k] = 1'b0;
                    cnt_model[k]  = cnt_model[k] + 8'd1;
                    delivered[k]++;
                end
            end
            if (in_valid && model_ready) begin
                sb_q[in_addr].push_back(in_data);
                model_full[in_addr] = 1'b1;
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] a, input logic [7:0] d, input logic [3:0] r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic       v;
        logic [1:0] a;
        logic [7:0] d;
        logic [3:0] r;
        logic       exp_ir;
        logic [3:0] exp_ov;
    } vec_t;

    vec_t vecs [9];
    logic [31:0] exp_wrap;
    int d_before;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_addr   = 2'd0;
        in_data   = 8'd0;
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            cnt_model[k] = 8'd0;
            delivered[k] = 0;
        end

        vecs[0] = '{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0000};
        vecs[1] = '{1'b1, 2'd2, 8'h5A, 4'b0000, 1'b0, 4'b0100};
        vecs[2] = '{1'b1, 2'd0, 8'h11, 4'b0000, 1'b1, 4'b0100};
        vecs[3] = '{1'b1, 2'd3, 8'h33, 4'b0000, 1'b1, 4'b0101};
        vecs[4] = '{1'b1, 2'd0, 8'h22, 4'b0000, 1'b0, 4'b1101};
        vecs[5] = '{1'b1, 2'd2, 8'h5A, 4'b0100, 1'b1, 4'b1101};
        vecs[6] = '{1'b0, 2'd1, 8'h00, 4'b0100, 1'b1, 4'b1101};
        vecs[7] = '{1'b0, 2'd1, 8'h00, 4'b1111, 1'b1, 4'b1001};
        vecs[8] = '{1'b0, 2'd1, 8'h00, 4'b0000, 1'b1, 4'b0000};

        #2;
        chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_xfer_cnt", xfer_cnt, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Vector table: routing, stall, independence, same-cycle drain+load
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].r);
            @(negedge clk);
            chk("vec_in_ready", {31'd0, in_ready}, {31'd0, vecs[i].exp_ir});
            chk("vec_out_valid", {28'd0, out_valid}, {28'd0, vecs[i].exp_ov});
            if (i == 1) chk("vec_ch2_data", {24'd0, out_data[23:16]}, 32'h0000_00A5);
            if (i == 4) chk("vec_ch0_kept", {24'd0, out_data[7:0]}, 32'h0000_0011);
        end

        // Back-to-back stream on channel 1
        d_before = delivered[1];
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 2'd1, 8'(i), 4'b0010);
            @(negedge clk);
            chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        end
        step(1'b0, 2'd1, 8'h00, 4'b0010);
        @(negedge clk);
        #1;
        chk("b2b_count", 32'(delivered[1] - d_before), 32'd16);

        // Counter wrap on channel 3
        do_reset();
        for (int i = 0; i < 257; i++) step(1'b1, 2'd3, 8'(i), 4'b1000);
        step(1'b0, 2'd0, 8'h00, 4'b1000);
        step(1'b0, 2'd0, 8'h00, 4'b0000);
        @(negedge clk);
`ifdef CHANNEL_DEMUX_COUNT_EN
        exp_wrap = 32'h0100_0000;
`else
        exp_wrap = 32'd0;
`endif
        chk("cnt_wrap", xfer_cnt, exp_wrap);

        // Random soak
        for (int i = 0; i < 10000; i++)
            step(1'($urandom_range(0, 2) != 0), 2'($urandom), 8'($urandom), 4'($urandom));
        step(1'b0, 2'd0, 8'h00, 4'b1111);
        step(1'b0, 2'd0, 8'h00, 4'b1111);
        @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) chk("soak_drained", 32'(sb_q[k].size()), 32'd0);

        // Fill all channels, then reset asynchronously mid-stream
        for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 8'(8'hC0 + k), 4'b0000);
        step(1'b1, 2'd0, 8'h99, 4'b0000);
        @(negedge clk);
        chk("pre_rst_full", {28'd0, out_valid}, 32'h0000_000F);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("mid_rst_xfer_cnt", xfer_cnt, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_out_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_addr  = 2'd0;
        in_data  = 8'h77;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("first_xfer_valid", {28'd0, out_valid}, 32'h0000_0001);
        chk("first_xfer_data", {24'd0, out_data[7:0]}, 32'h0000_0077);
        step(1'b0, 2'd0, 8'h00, 4'b1111);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
